// File: rtl/mm_wr_scheduler.sv
// Shares one local-memory write port round-robin among NCH channel streams, each writing a host-sized block at its own base.
// Latency: a handshake in cycle t produces the memory write in cycle t+1; throughput is 1 word per cycle. Backpressure: ch_ready is at most one-hot and only high in RUN.
module mm_wr_scheduler #(
    parameter int NCH = 2,
    parameter int DW  = 32,
    parameter int AW  = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [NCH*AW-1:0]     cfg_base,
    input  logic [NCH*(AW+1)-1:0] cfg_size,
    input  logic [NCH-1:0]        ch_valid,
    input  logic [NCH*DW-1:0]     ch_data,
    output logic [NCH-1:0]        ch_ready,
    output logic [NCH-1:0]        ch_last,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   base_q [NCH];
    logic [AW-1:0]   base_d [NCH];
    logic [AW:0]     size_q [NCH];
    logic [AW:0]     size_d [NCH];
    logic [AW:0]     cnt_q  [NCH];
    logic [AW:0]     cnt_d  [NCH];
    logic [NCH-1:0]  fin_q, fin_d;
    logic            mem_en_q, mem_en_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic [NCH-1:0]  elig, grant, last;
    logic            xfer;
    int              gidx;
    int              idx;

    // Round-robin search starting at the pointer; the first eligible channel wins.
    always_comb begin
        elig  = '0;
        grant = '0;
        last  = '0;
        xfer  = 1'b0;
        gidx  = 0;
        idx   = 0;
        if (state_q == RUN) elig = ch_valid & ~fin_q;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!xfer && elig[idx]) begin
                xfer = 1'b1;
                gidx = idx;
            end
        end
        if (xfer) grant[gidx] = 1'b1;
        for (int i = 0; i < NCH; i++)
            last[i] = grant[i] && (cnt_q[i] == size_q[i] - 1'b1);
    end

    assign ch_ready = grant;
    assign ch_last  = last;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        base_d      = base_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        fin_d       = fin_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int i = 0; i < NCH; i++) begin
                        base_d[i] = cfg_base[i*AW +: AW];
                        size_d[i] = cfg_size[i*(AW+1) +: AW+1];
                        cnt_d[i]  = '0;
                        fin_d[i]  = (cfg_size[i*(AW+1) +: AW+1] == '0);
                    end
                    state_d = (&fin_d) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_d[gidx] = cnt_q[gidx] + 1'b1;
                    if (last[gidx]) fin_d[gidx] = 1'b1;
                    ptr_d       = (gidx + 1 >= NCH) ? '0 : PW'(gidx + 1);
                    mem_en_d    = 1'b1;
                    mem_addr_d  = base_q[gidx] + cnt_q[gidx][AW-1:0];
                    mem_wdata_d = ch_data[gidx*DW +: DW];
                end
                // Leaving on the final handshake lines DONE up with the final write.
                if (&fin_d) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            fin_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                base_q[i] <= '0;
                size_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fin_q       <= fin_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            for (int i = 0; i < NCH; i++) begin
                base_q[i] <= base_d[i];
                size_q[i] <= size_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
endmodule
